// File: rtl/rambus_pkg.sv
// Shared constants and the round-robin pick helper for the RamBus arbiter.
package rambus_pkg;

    localparam int          RB_ADDR_W   = 14;
    localparam int          RB_DATA_W   = 32;
    localparam logic [31:0] RB_ERR_DATA = 32'hDEADBEEF;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SETUP  = 2'd1;
    localparam state_t ST_ACCESS = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

    // Returns the winning port (0 = M0, 1 = M1); under contention the port not granted last wins.
    function automatic logic rr_pick(input logic req0, input logic req1, input logic last_grant);
        logic pick;
        if (req0 && req1) begin
            pick = ~last_grant;
        end else if (req1) begin
            pick = 1'b1;
        end else begin
            pick = 1'b0;
        end
        return pick;
    endfunction

endpackage

// File: rtl/rambus_watchdog.sv
// Saturating cycle counter that flags TIMEOUT-1 cycles spent waiting for RamBusAck.
module rambus_watchdog #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic nRst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_r;

    // Count while enabled, stop at LAST so a stuck access cannot wrap back to zero.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (enable && (cnt_r != LAST)) begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = (cnt_r == LAST);

endmodule

// File: rtl/rambus_arbiter.sv
// Two-port arbiter onto the DMMainPorts RamBus: round-robin grant, SETUP/ACCESS/DONE sequencing, Ack watchdog.
module rambus_arbiter
    import rambus_pkg::*;
#(
    parameter int                ADDR_W   = RB_ADDR_W,
    parameter int                DATA_W   = RB_DATA_W,
    parameter int                TIMEOUT  = 256,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(RB_ERR_DATA)
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              M0Sel,
    input  logic              M0Enable,
    input  logic              M0Write,
    input  logic [ADDR_W-1:0] M0Addr,
    input  logic [DATA_W-1:0] M0WData,
    output logic [DATA_W-1:0] M0RData,
    output logic              M0Ready,
    output logic              M0SlvErr,
    input  logic              M1Req,
    input  logic              M1Write,
    input  logic [ADDR_W-1:0] M1Addr,
    input  logic [DATA_W-1:0] M1WData,
    output logic [DATA_W-1:0] M1RData,
    output logic              M1Ack,
    output logic              M1Err,
    output logic [ADDR_W-1:0] RamBusAddress,
    output logic [DATA_W-1:0] RamBusDataIn,
    output logic              RamBusnCs,
    output logic              RamBusWrnRd,
    output logic              RamBusLatch,
    input  logic [DATA_W-1:0] RamBusDataOut,
    input  logic              RamBusAck
);

    state_t state_r;
    logic   grant_r;
    logic   last_grant_r;
    logic   any_req_s;
    logic   pick_s;
    logic   clear_s;
    logic   enable_s;
    logic   expired_s;
    logic   unused_s;

    assign any_req_s = M0Sel | M1Req;
    assign pick_s    = rr_pick(M0Sel, M1Req, last_grant_r);
    assign clear_s   = (state_r == ST_IDLE) && any_req_s;
    assign enable_s  = (state_r == ST_ACCESS);
    assign unused_s  = M0Enable;

    rambus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .nRst    (nRst),
        .clear   (clear_s),
        .enable  (enable_s),
        .expired (expired_s)
    );

    // Transfer sequencer; all bus and requester outputs are driven from here as registers.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_r       <= ST_IDLE;
            grant_r       <= 1'b0;
            last_grant_r  <= 1'b1;   // makes M0 the first winner under contention
            M0RData       <= '0;
            M0Ready       <= 1'b0;
            M0SlvErr      <= 1'b0;
            M1RData       <= '0;
            M1Ack         <= 1'b0;
            M1Err         <= 1'b0;
            RamBusAddress <= '0;
            RamBusDataIn  <= '0;
            RamBusnCs     <= 1'b0;
            RamBusWrnRd   <= 1'b0;
            RamBusLatch   <= 1'b0;
        end else begin
            M0Ready  <= 1'b0;
            M0SlvErr <= 1'b0;
            M1Ack    <= 1'b0;
            M1Err    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        grant_r       <= pick_s;
                        last_grant_r  <= pick_s;
                        RamBusAddress <= pick_s ? M1Addr  : M0Addr;
                        RamBusDataIn  <= pick_s ? M1WData : M0WData;
                        RamBusWrnRd   <= pick_s ? M1Write : M0Write;
                        RamBusnCs     <= 1'b1;
                        state_r       <= ST_SETUP;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    RamBusLatch <= 1'b1;
                    state_r     <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // A real Ack wins over a same-cycle expiry.
                    if (RamBusAck || expired_s) begin
                        RamBusnCs   <= 1'b0;
                        RamBusLatch <= 1'b0;
                        RamBusWrnRd <= 1'b0;
                        state_r     <= ST_DONE;
                        if (grant_r) begin
                            M1Ack <= 1'b1;
                            M1Err <= ~RamBusAck;
                            if (!RamBusAck) begin
                                M1RData <= ERR_DATA;
                            end else if (!RamBusWrnRd) begin
                                M1RData <= RamBusDataOut;
                            end else begin
                                M1RData <= M1RData;
                            end
                        end else begin
                            M0Ready  <= 1'b1;
                            M0SlvErr <= ~RamBusAck;
                            if (!RamBusAck) begin
                                M0RData <= ERR_DATA;
                            end else if (!RamBusWrnRd) begin
                                M0RData <= RamBusDataOut;
                            end else begin
                                M0RData <= M0RData;
                            end
                        end
                    end else begin
                        state_r <= ST_ACCESS;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rambus_arbiter.sv
// Scoreboard bench for rambus_arbiter: directed latency/arbitration/timeout/reset cases plus random traffic.
module tb_rambus_arbiter;

    logic        clk = 1'b0;
    logic        nRst = 1'b0;
    logic        M0Sel = 1'b0, M0Enable = 1'b0, M0Write = 1'b0;
    logic [13:0] M0Addr = 14'd0;
    logic [31:0] M0WData = 32'd0, M0RData;
    logic        M0Ready, M0SlvErr;
    logic        M1Req = 1'b0, M1Write = 1'b0;
    logic [13:0] M1Addr = 14'd0;
    logic [31:0] M1WData = 32'd0, M1RData;
    logic        M1Ack, M1Err;
    logic [13:0] RamBusAddress;
    logic [31:0] RamBusDataIn;
    logic        RamBusnCs, RamBusWrnRd, RamBusLatch;
    logic [31:0] RamBusDataOut = 32'd0;
    logic        RamBusAck = 1'b0;

    rambus_arbiter dut (
        .clk(clk), .nRst(nRst),
        .M0Sel(M0Sel), .M0Enable(M0Enable), .M0Write(M0Write), .M0Addr(M0Addr),
        .M0WData(M0WData), .M0RData(M0RData), .M0Ready(M0Ready), .M0SlvErr(M0SlvErr),
        .M1Req(M1Req), .M1Write(M1Write), .M1Addr(M1Addr), .M1WData(M1WData),
        .M1RData(M1RData), .M1Ack(M1Ack), .M1Err(M1Err),
        .RamBusAddress(RamBusAddress), .RamBusDataIn(RamBusDataIn), .RamBusnCs(RamBusnCs),
        .RamBusWrnRd(RamBusWrnRd), .RamBusLatch(RamBusLatch),
        .RamBusDataOut(RamBusDataOut), .RamBusAck(RamBusAck)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    // Reference state: word contents of the slave and the RData each port should hold.
    logic [31:0] ref_mem [0:16383];
    logic [31:0] slv_mem [0:16383];
    logic [31:0] exp_rd [0:1];

    // Transfer currently requested by each port, for checking what appears on the bus.
    logic        act [0:1];
    logic        act_wr [0:1];
    logic [13:0] act_addr [0:1];
    logic [31:0] act_wd [0:1];

    // Slave behaviour knobs.
    int  ack_delay = 0;
    bit  no_ack = 1'b0;
    bit  rand_dly = 1'b0;
    bit  stray = 1'b0;
    bit  stray_rand = 1'b0;
    int  latch_len = 0;

    task automatic chk(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act_v, exp_v);
        end
    endtask

    // Issue one transfer on port p; lat is the expected response cycle offset from the sampling edge (-1 = unchecked).
    task automatic xfer(input int p, input logic wr, input logic [13:0] addr, input logic [31:0] wd,
                        input int lat, input bit tmo);
        exp_t e;
        int   k;
        @(negedge clk);
        if (tmo) begin
            exp_rd[p] = 32'hDEADBEEF;
        end else if (wr) begin
            ref_mem[addr] = wd;
        end else begin
            exp_rd[p] = ref_mem[addr];
        end
        e.rdata = exp_rd[p];
        e.err   = tmo;
        e.cyc   = (lat < 0) ? -1 : cyc + 1 + lat;
        act_wr[p] = wr; act_addr[p] = addr; act_wd[p] = wd; act[p] = 1'b1;
        if (p == 0) begin
            q0.push_back(e);
            M0Write = wr; M0Addr = addr; M0WData = wd; M0Sel = 1'b1; M0Enable = 1'b1;
        end else begin
            q1.push_back(e);
            M1Write = wr; M1Addr = addr; M1WData = wd; M1Req = 1'b1;
        end
        for (k = 0; k < 2000; k++) begin
            @(negedge clk);
            if ((p == 0) ? M0Ready : M1Ack) break;
        end
        if (k == 2000) begin
            checks++; errors++;
            $display("FAIL port%0d_completion: got no response within 2000 cycles, required one", p);
        end
        if (p == 0) begin
            M0Sel = 1'b0; M0Enable = 1'b0;
        end else begin
            M1Req = 1'b0;
        end
        act[p] = 1'b0;
    endtask

    // Port 0 monitor.
    initial forever begin
        @(negedge clk);
        if (M0Ready) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL m0_unexpected_ready: got M0Ready=1 at cycle %0d, required 0", cyc);
            end else begin
                exp_t e;
                e = q0.pop_front();
                chk("m0_rdata", {32'd0, M0RData}, {32'd0, e.rdata});
                chk("m0_slverr", {63'd0, M0SlvErr}, {63'd0, e.err});
                if (e.cyc >= 0) chk("m0_latency", 64'(cyc), 64'(e.cyc));
            end
        end else if (M0SlvErr) begin
            checks++; errors++;
            $display("FAIL m0_slverr_idle: got M0SlvErr=1 without M0Ready, required 0");
        end
    end

    // Port 1 monitor.
    initial forever begin
        @(negedge clk);
        if (M1Ack) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL m1_unexpected_ack: got M1Ack=1 at cycle %0d, required 0", cyc);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("m1_rdata", {32'd0, M1RData}, {32'd0, e.rdata});
                chk("m1_err", {63'd0, M1Err}, {63'd0, e.err});
                if (e.cyc >= 0) chk("m1_latency", 64'(cyc), 64'(e.cyc));
            end
        end else if (M1Err) begin
            checks++; errors++;
            $display("FAIL m1_err_idle: got M1Err=1 without M1Ack, required 0");
        end
    end

    // Slave model: acks ack_delay cycles into the Latch phase and checks the bus against the owning port.
    int lat_cnt = 0;
    int cur_dly = 0;
    initial forever begin
        @(negedge clk);
        if (!nRst) begin
            RamBusAck = 1'b0;
            lat_cnt = 0;
        end else if (RamBusLatch) begin
            if (lat_cnt == 0) cur_dly = rand_dly ? int'($urandom_range(0, 4)) : ack_delay;
            if (!no_ack && (lat_cnt == cur_dly)) begin
                int port;
                port = int'(RamBusAddress[13]);
                if (!act[port]) begin
                    checks++; errors++;
                    $display("FAIL bus_owner: got access to %0h, required a pending request from port %0d", RamBusAddress, port);
                end else begin
                    chk("bus_addr", {50'd0, RamBusAddress}, {50'd0, act_addr[port]});
                    chk("bus_wrnrd", {63'd0, RamBusWrnRd}, {63'd0, act_wr[port]});
                    chk("bus_cs", {63'd0, RamBusnCs}, 64'd1);
                    if (act_wr[port]) chk("bus_wdata", {32'd0, RamBusDataIn}, {32'd0, act_wd[port]});
                end
                if (RamBusWrnRd) slv_mem[RamBusAddress] = RamBusDataIn;
                RamBusDataOut = slv_mem[RamBusAddress];
                RamBusAck = 1'b1;
            end else begin
                RamBusAck = 1'b0;
                RamBusDataOut = $urandom;
            end
            lat_cnt++;
        end else begin
            if (lat_cnt > 0) latch_len = lat_cnt;
            lat_cnt = 0;
            RamBusAck = stray ? 1'b1 : (stray_rand ? 1'($urandom_range(0, 1)) : 1'b0);
            RamBusDataOut = $urandom;
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctrl"}, {57'd0, M0Ready, M0SlvErr, M1Ack, M1Err, RamBusnCs, RamBusWrnRd, RamBusLatch}, 64'd0);
        chk({tag, "_rdata"}, {M0RData, M1RData}, 64'd0);
        chk({tag, "_bus"}, {18'd0, RamBusAddress, RamBusDataIn}, 64'd0);
    endtask

    initial begin
        int k;
        for (int a = 0; a < 16384; a++) begin
            slv_mem[a] = 32'hC0DE0000 + 32'(a) * 32'd7;
            ref_mem[a] = 32'hC0DE0000 + 32'(a) * 32'd7;
        end
        slv_mem[14'h0010] = 32'h12345678;
        ref_mem[14'h0010] = 32'h12345678;
        exp_rd[0] = 32'd0; exp_rd[1] = 32'd0;
        act[0] = 1'b0; act[1] = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        nRst = 1'b1;
        repeat (2) @(negedge clk);

        // Simultaneous requests right after reset: M0 first, M1 after one idle cycle.
        fork
            xfer(0, 1'b0, 14'h0100, 32'd0, 2, 1'b0);
            xfer(1, 1'b0, 14'h2100, 32'd0, 6, 1'b0);
        join
        xfer(0, 1'b0, 14'h0101, 32'd0, 2, 1'b0);
        // Last grant was M0, so contention now goes to M1.
        fork
            xfer(0, 1'b0, 14'h0102, 32'd0, 6, 1'b0);
            xfer(1, 1'b0, 14'h2102, 32'd0, 2, 1'b0);
        join

        // Read with Ack one cycle after Latch.
        ack_delay = 1;
        xfer(0, 1'b0, 14'h0010, 32'd0, 3, 1'b0);
        // Write at the top address with immediate Ack, then read it back.
        ack_delay = 0;
        xfer(1, 1'b1, 14'h3FFF, 32'hA5A5A5A5, 2, 1'b0);
        xfer(1, 1'b0, 14'h3FFF, 32'd0, 2, 1'b0);

        // Watchdog: no Ack at all.
        no_ack = 1'b1;
        xfer(0, 1'b0, 14'h0020, 32'd0, 257, 1'b1);
        no_ack = 1'b0;
        @(negedge clk);
        chk("timeout_latch_len", 64'(latch_len), 64'd256);

        // Stray Acks outside ACCESS must not end the transfer early.
        stray = 1'b1; ack_delay = 2;
        xfer(0, 1'b0, 14'h0030, 32'd0, 4, 1'b0);
        stray = 1'b0; ack_delay = 0;

        // Reset in the middle of ACCESS.
        no_ack = 1'b1;
        @(negedge clk);
        M0Write = 1'b0; M0Addr = 14'h0040; M0Sel = 1'b1; M0Enable = 1'b1;
        act_wr[0] = 1'b0; act_addr[0] = 14'h0040; act[0] = 1'b1;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (RamBusLatch) break;
        end
        chk("reset_reach_access", {63'd0, RamBusLatch}, 64'd1);
        repeat (3) @(negedge clk);
        nRst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        M0Sel = 1'b0; M0Enable = 1'b0; act[0] = 1'b0; no_ack = 1'b0;
        exp_rd[0] = 32'd0; exp_rd[1] = 32'd0;
        repeat (3) @(negedge clk);
        nRst = 1'b1;
        repeat (10) @(negedge clk);
        xfer(0, 1'b0, 14'h0040, 32'd0, 2, 1'b0);
        fork
            xfer(0, 1'b1, 14'h0041, 32'h0BADF00D, 6, 1'b0);
            xfer(1, 1'b1, 14'h2041, 32'h600DCAFE, 2, 1'b0);
        join

        // Random traffic from both ports with random Ack delays and stray Acks.
        rand_dly = 1'b1; stray_rand = 1'b1;
        fork
            for (int i = 0; i < 60; i++) begin
                xfer(0, 1'($urandom_range(0, 1)), 14'($urandom_range(0, 7)), $urandom, -1, 1'b0);
                repeat ($urandom_range(2, 4)) @(negedge clk);
            end
            for (int j = 0; j < 60; j++) begin
                xfer(1, 1'($urandom_range(0, 1)), 14'h2000 | 14'($urandom_range(0, 7)), $urandom, -1, 1'b0);
                repeat ($urandom_range(2, 4)) @(negedge clk);
            end
        join
        rand_dly = 1'b0; stray_rand = 1'b0;

        repeat (10) @(negedge clk);
        chk("q0_drained", 64'(q0.size()), 64'd0);
        chk("q1_drained", 64'(q1.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
